// File: rtl/ysyx_25060170_wb_arb_pkg.sv
// Shared definitions for the writeback arbiter and its neighbours (WBU/IDU).
// Optional macro YSYX_25060170_WB_COMMIT_TRACE_EN adds a PC field to requests.
package ysyx_25060170_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  // Source encoding used for both the grant select and the age flag
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // Writeback data select, shared with WBU/IDU
  typedef enum logic [1:0] {
    REGS_ALU = 2'd0,
    REGS_MEM = 2'd1,
    REGS_PC4 = 2'd2
  } regs_e;

  // One buffered writeback request
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              regw;
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    logic [31:0]       pc;
`endif
  } wb_req_t;

  // x0 is hardwired to zero, so a request only writes when regw is set and rd is non-zero
  function automatic logic wr_en(input wb_req_t r);
    return r.regw && (r.rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_25060170_wb_arb_if.sv
// Producer/register-file bus of the writeback arbiter.
// Optional macro YSYX_25060170_WB_COMMIT_TRACE_EN adds the commit trace signals.
interface ysyx_25060170_wb_arb_if;
  import ysyx_25060170_pkg::*;

  logic              exu_valid_i;
  logic              exu_ready_o;
  logic [REG_AW-1:0] exu_rd_i;
  logic [XLEN-1:0]   exu_data_i;
  logic              exu_regw_i;

  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [XLEN-1:0]   lsu_data_i;

  logic              ld_issue_i;
  logic [REG_AW-1:0] ld_issue_rd_i;

  logic              reg_write_en_o;
  logic [REG_AW-1:0] reg_write_addr_o;
  logic [XLEN-1:0]   reg_write_data_o;
  logic [NREG-1:0]   busy_o;
  logic              wb_done_o;

`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
  logic [31:0]       exu_pc_i;
  logic              commit_valid_o;
  logic [31:0]       commit_pc_o;
`endif

  // Arbiter side
  modport slave (
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    input  exu_pc_i,
    output commit_valid_o, commit_pc_o,
`endif
    input  exu_valid_i, exu_rd_i, exu_data_i, exu_regw_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  ld_issue_i, ld_issue_rd_i,
    output exu_ready_o, lsu_ready_o,
    output reg_write_en_o, reg_write_addr_o, reg_write_data_o,
    output busy_o, wb_done_o
  );

  // Producer / observer side
  modport master (
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    output exu_pc_i,
    input  commit_valid_o, commit_pc_o,
`endif
    output exu_valid_i, exu_rd_i, exu_data_i, exu_regw_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output ld_issue_i, ld_issue_rd_i,
    input  exu_ready_o, lsu_ready_o,
    input  reg_write_en_o, reg_write_addr_o, reg_write_data_o,
    input  busy_o, wb_done_o
  );

endinterface

// File: rtl/ysyx_25060170_wb_arb_slot.sv
// One-entry request buffer with valid/ready. Ready is also high on the cycle
// the entry is granted, so a producer can refill it on the same edge it drains.
module ysyx_25060170_wb_slot
  import ysyx_25060170_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  wb_req_t i_req,
  input  logic    i_grant,
  output logic    o_ready,
  output logic    o_fill,
  output logic    o_valid,
  output wb_req_t o_req
);

  logic    r_valid;
  wb_req_t r_req;

  assign o_ready = !r_valid || i_grant;
  assign o_fill  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_req   = r_req;

  // Occupancy: fill wins over drain so a same-edge refill keeps the slot full
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (o_fill) begin
      r_valid <= 1'b1;
    end else if (i_grant) begin
      r_valid <= 1'b0;
    end
  end

  // Payload capture on every accepted request
  // NOTE: the payload is gated by r_valid downstream, so its reset only keeps the bus free of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (o_fill) begin
      r_req <= i_req;
    end
  end

endmodule

// File: rtl/ysyx_25060170_wb_arb.sv
// GPR write-port arbiter and load scoreboard between EXU/LSU and the register file.
// Optional macro YSYX_25060170_WB_COMMIT_TRACE_EN adds EXU commit PC tracing.
module ysyx_25060170_wb_arb
  import ysyx_25060170_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  ysyx_25060170_wb_arb_if.slave bus
);

  wb_req_t         w_exu_req;
  wb_req_t         w_lsu_req;
  wb_req_t         w_exu_slot;
  wb_req_t         w_lsu_slot;
  wb_req_t         w_gnt_req;
  logic            w_exu_v;
  logic            w_lsu_v;
  logic            w_exu_fill;
  logic            w_lsu_fill;
  logic            w_gnt_any;
  logic            w_gnt_src;
  logic            w_gnt_exu;
  logic            w_gnt_lsu;
  logic            w_tie_used;
  logic [NREG-1:0] w_busy_next;

  logic            r_age;   // older slot when both are valid and not a tie
  logic            r_tie;   // both slots were filled on the same edge
  logic            r_rr;    // tie-break pointer
  logic [NREG-1:0] r_busy;

  // Pack producer inputs into request structs; LSU loads always write
  always_comb begin
    w_exu_req      = '0;
    w_exu_req.rd   = bus.exu_rd_i;
    w_exu_req.data = bus.exu_data_i;
    w_exu_req.regw = bus.exu_regw_i;
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    w_exu_req.pc   = bus.exu_pc_i;
`endif
    w_lsu_req      = '0;
    w_lsu_req.rd   = bus.lsu_rd_i;
    w_lsu_req.data = bus.lsu_data_i;
    w_lsu_req.regw = 1'b1;
  end

  ysyx_25060170_wb_slot u_exu_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.exu_valid_i),
    .i_req   (w_exu_req),
    .i_grant (w_gnt_exu),
    .o_ready (bus.exu_ready_o),
    .o_fill  (w_exu_fill),
    .o_valid (w_exu_v),
    .o_req   (w_exu_slot)
  );

  ysyx_25060170_wb_slot u_lsu_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.lsu_valid_i),
    .i_req   (w_lsu_req),
    .i_grant (w_gnt_lsu),
    .o_ready (bus.lsu_ready_o),
    .o_fill  (w_lsu_fill),
    .o_valid (w_lsu_v),
    .o_req   (w_lsu_slot)
  );

  // Grant select: lone valid slot, else the older one, else round-robin on a tie
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_src  = SRC_EXU;
    w_tie_used = 1'b0;
    unique case ({w_exu_v, w_lsu_v})
      2'b10: begin
        w_gnt_any = 1'b1;
        w_gnt_src = SRC_EXU;
      end
      2'b01: begin
        w_gnt_any = 1'b1;
        w_gnt_src = SRC_LSU;
      end
      2'b11: begin
        w_gnt_any = 1'b1;
        if (r_tie) begin
          w_gnt_src  = r_rr;
          w_tie_used = 1'b1;
        end else begin
          w_gnt_src  = r_age;
        end
      end
      default: ;
    endcase
  end

  assign w_gnt_exu = w_gnt_any && (w_gnt_src == SRC_EXU);
  assign w_gnt_lsu = w_gnt_any && (w_gnt_src == SRC_LSU);

  // Write port driven purely from slot state; idle port is all zeros
  always_comb begin
    w_gnt_req            = '0;
    bus.reg_write_en_o   = 1'b0;
    bus.reg_write_addr_o = '0;
    bus.reg_write_data_o = '0;
    if (w_gnt_any) begin
      w_gnt_req            = (w_gnt_src == SRC_LSU) ? w_lsu_slot : w_exu_slot;
      bus.reg_write_en_o   = wr_en(w_gnt_req);
      bus.reg_write_addr_o = w_gnt_req.rd;
      bus.reg_write_data_o = w_gnt_req.data;
    end
  end

  assign bus.wb_done_o = w_gnt_any;

`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
  assign bus.commit_valid_o = w_gnt_exu;
  assign bus.commit_pc_o    = w_gnt_exu ? w_exu_slot.pc : 32'd0;
`endif

  // Age tracking: the slot that was not refilled is the older one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age <= SRC_EXU;
      r_tie <= 1'b0;
      r_rr  <= SRC_EXU;
    end else begin
      if (w_tie_used) begin
        r_rr <= ~r_rr;
      end
      if (w_exu_fill && w_lsu_fill) begin
        r_tie <= 1'b1;
      end else if (w_exu_fill) begin
        r_tie <= 1'b0;
        r_age <= SRC_LSU;
      end else if (w_lsu_fill) begin
        r_tie <= 1'b0;
        r_age <= SRC_EXU;
      end
    end
  end

  // Scoreboard next state: a retiring load clears, a new issue sets and wins
  always_comb begin
    w_busy_next = r_busy;
    if (w_gnt_lsu) begin
      w_busy_next[w_lsu_slot.rd] = 1'b0;
    end
    if (bus.ld_issue_i && (bus.ld_issue_rd_i != '0)) begin
      w_busy_next[bus.ld_issue_rd_i] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign bus.busy_o = r_busy;

endmodule

// File: tb/tb_ysyx_25060170_wb_arb.sv
// Self-checking bench for ysyx_25060170_wb_arb: directed scenarios with literal
// expectations, then randomized traffic against a timestamp-based slot model.
module tb_ysyx_25060170_wb_arb;
  import ysyx_25060170_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25060170_wb_arb_if bus ();

  ysyx_25060170_wb_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: each slot remembers the cycle it was filled; oldest timestamp wins
  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          regw;
    logic [31:0] pc;
    int          t;
  } mslot_t;

  mslot_t      me;
  mslot_t      ml;
  bit          m_rr;
  logic [31:0] m_busy;
  int          cyc;
  bit          acc_e;
  bit          acc_l;
  bit          hold_e;
  bit          hold_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    me     = '{v: 0, rd: '0, data: '0, regw: 0, pc: '0, t: 0};
    ml     = '{v: 0, rd: '0, data: '0, regw: 0, pc: '0, t: 0};
    m_rr   = 0;
    m_busy = '0;
  endtask

  task automatic set_exu(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit regw);
    bus.exu_valid_i = v;
    bus.exu_rd_i    = rd;
    bus.exu_data_i  = d;
    bus.exu_regw_i  = regw;
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    bus.exu_pc_i    = $urandom;
`endif
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid_i = v;
    bus.lsu_rd_i    = rd;
    bus.lsu_data_i  = d;
  endtask

  task automatic set_ld(input bit v, input logic [4:0] rd);
    bus.ld_issue_i    = v;
    bus.ld_issue_rd_i = rd;
  endtask

  // Called just after a negedge: compare outputs, advance model over the next posedge
  task automatic step();
    bit          ge;
    bit          gl;
    bit          tie;
    bit          en;
    logic [4:0]  addr;
    logic [31:0] data;
    ge = 0; gl = 0; tie = 0;
    if (me.v && ml.v) begin
      if (me.t < ml.t)      ge = 1;
      else if (ml.t < me.t) gl = 1;
      else begin
        tie = 1;
        if (m_rr) gl = 1; else ge = 1;
      end
    end else if (me.v) ge = 1;
    else if (ml.v)     gl = 1;

    en = 0; addr = '0; data = '0;
    if (ge) begin
      en = me.regw && (me.rd != 0); addr = me.rd; data = me.data;
    end else if (gl) begin
      en = (ml.rd != 0); addr = ml.rd; data = ml.data;
    end

    check("reg_write_en",   bus.reg_write_en_o,   en);
    check("reg_write_addr", bus.reg_write_addr_o, addr);
    check("reg_write_data", bus.reg_write_data_o, data);
    check("wb_done",        bus.wb_done_o,        ge || gl);
    check("exu_ready",      bus.exu_ready_o,      !me.v || ge);
    check("lsu_ready",      bus.lsu_ready_o,      !ml.v || gl);
    check("busy",           bus.busy_o,           m_busy);
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
    check("commit_valid",   bus.commit_valid_o,   ge);
    if (ge) check("commit_pc", bus.commit_pc_o, me.pc);
`endif

    acc_e = bus.exu_valid_i && (!me.v || ge);
    acc_l = bus.lsu_valid_i && (!ml.v || gl);
    if (gl) m_busy[ml.rd] = 1'b0;
    if (bus.ld_issue_i && bus.ld_issue_rd_i != 0) m_busy[bus.ld_issue_rd_i] = 1'b1;
    if (tie) m_rr = !m_rr;
    if (acc_e) begin
      me.v = 1; me.rd = bus.exu_rd_i; me.data = bus.exu_data_i;
      me.regw = bus.exu_regw_i; me.t = cyc + 1;
`ifdef YSYX_25060170_WB_COMMIT_TRACE_EN
      me.pc = bus.exu_pc_i;
`endif
    end else if (ge) me.v = 0;
    if (acc_l) begin
      ml.v = 1; ml.rd = bus.lsu_rd_i; ml.data = bus.lsu_data_i; ml.regw = 1; ml.t = cyc + 1;
    end else if (gl) ml.v = 0;
    cyc++;
    @(negedge clk);
  endtask

  // Bound on total run time
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    hold_e = 0;
    hold_l = 0;
    model_reset();
    set_exu(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    set_ld(0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_en",   bus.reg_write_en_o, 1'b0);
    check("rst_busy", bus.busy_o,         32'h0);
    check("rst_done", bus.wb_done_o,      1'b0);
    rst = 1'b0;
    #1;
    check("rel_exu_ready", bus.exu_ready_o, 1'b1);
    check("rel_lsu_ready", bus.lsu_ready_o, 1'b1);
    step();

    // Back-to-back EXU writes, one per cycle
    set_exu(1, 5'd5, 32'h1234, 1);
    step();
    set_exu(1, 5'd6, 32'h5678, 1);
    check("b2b_en",    bus.reg_write_en_o,   1'b1);
    check("b2b_addr",  bus.reg_write_addr_o, 5'd5);
    check("b2b_data",  bus.reg_write_data_o, 32'h1234);
    check("b2b_ready", bus.exu_ready_o,      1'b1);
    step();
    set_exu(0, 0, 0, 0);
    check("b2b_addr2", bus.reg_write_addr_o, 5'd6);
    check("b2b_data2", bus.reg_write_data_o, 32'h5678);
    step();

    // Same-edge fill: round-robin starts at EXU, then alternates
    for (int rep = 0; rep < 2; rep++) begin
      set_exu(1, 5'd3, 32'hA, 1);
      set_lsu(1, 5'd4, 32'hB);
      step();
      set_exu(0, 0, 0, 0);
      set_lsu(0, 0, 0);
      check("rr_first_addr",  bus.reg_write_addr_o, (rep == 0) ? 5'd3 : 5'd4);
      check("rr_first_data",  bus.reg_write_data_o, (rep == 0) ? 32'hA : 32'hB);
      step();
      check("rr_second_addr", bus.reg_write_addr_o, (rep == 0) ? 5'd4 : 5'd3);
      step();
    end

    // Scoreboard set, clear on grant, and set-wins on collision
    set_ld(1, 5'd7);
    step();
    set_ld(0, 0);
    check("sb_set", bus.busy_o[7], 1'b1);
    set_lsu(1, 5'd7, 32'h77);
    step();
    set_lsu(0, 0, 0);
    set_ld(1, 5'd7);
    check("sb_ld_addr", bus.reg_write_addr_o, 5'd7);
    check("sb_ld_en",   bus.reg_write_en_o,   1'b1);
    step();
    set_ld(0, 0);
    check("sb_set_wins", bus.busy_o[7], 1'b1);
    set_lsu(1, 5'd7, 32'h78);
    step();
    set_lsu(0, 0, 0);
    step();
    check("sb_clear", bus.busy_o[7], 1'b0);

    // x0 write is consumed but not written
    set_exu(1, 5'd0, 32'hFFFF, 1);
    step();
    set_exu(0, 0, 0, 0);
    check("x0_done", bus.wb_done_o,      1'b1);
    check("x0_en",   bus.reg_write_en_o, 1'b0);
    step();

    // LSU held while its slot is full and not granted
    set_exu(1, 5'd10, 32'h10, 1);
    set_lsu(1, 5'd8, 32'h88);
    step();
    set_exu(0, 0, 0, 0);
    set_lsu(1, 5'd9, 32'h99);
    check("hold_ready0", bus.lsu_ready_o,      1'b0);
    check("hold_addr10", bus.reg_write_addr_o, 5'd10);
    step();
    check("hold_addr8",  bus.reg_write_addr_o, 5'd8);
    check("hold_data8",  bus.reg_write_data_o, 32'h88);
    check("hold_ready1", bus.lsu_ready_o,      1'b1);
    step();
    set_lsu(0, 0, 0);
    check("hold_addr9",  bus.reg_write_addr_o, 5'd9);
    check("hold_data9",  bus.reg_write_data_o, 32'h99);
    step();

    // Asynchronous reset with both slots full and a load in flight
    set_exu(1, 5'd14, 32'hE, 1);
    set_lsu(1, 5'd15, 32'hF);
    set_ld(1, 5'd20);
    step();
    set_exu(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    set_ld(0, 0);
    check("pre_rst_busy", bus.busy_o,         32'h0010_0000);
    check("pre_rst_en",   bus.reg_write_en_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en",   bus.reg_write_en_o, 1'b0);
    check("mid_rst_busy", bus.busy_o,         32'h0);
    check("mid_rst_done", bus.wb_done_o,      1'b0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_en", bus.reg_write_en_o, 1'b0);
    repeat (3) step();

    // Randomized traffic with producers that hold while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!hold_e) begin
        set_exu($urandom_range(0, 99) < 60,
                ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                $urandom, $urandom_range(0, 3) != 0);
      end
      if (!hold_l) begin
        set_lsu($urandom_range(0, 99) < 55,
                ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                $urandom);
      end
      set_ld($urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)));
      step();
      hold_e = bus.exu_valid_i && !acc_e;
      hold_l = bus.lsu_valid_i && !acc_l;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
